// File: rtl/audioplay_proce_cpu_debug_pkg.sv
// Shared types and jdo field positions for the CPU debug memory bridge.
package audioplay_proce_cpu_debug_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  localparam int JDO_W        = 38;
  localparam int DATA_W       = 32;
  localparam int JDO_ADDR_LSB = 8;
  localparam int JDO_RD_BIT   = 34;
  localparam int JDO_CLR_BIT  = 33;
  localparam int JDO_DATA_LSB = 3;

endpackage

// File: rtl/audioplay_proce_cpu_debug_req_timer.sv
// Saturating 8-bit counter of stalled request cycles. expired asserts in the
// cycle whose stall brings the count up to TIMEOUT, so the owner can abort on
// that same clock edge.
module audioplay_proce_cpu_debug_req_timer #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;
  logic [7:0] count_next;

  // Next count value, held at all-ones so a long stall cannot wrap to zero.
  always_comb begin
    count_next = (count == 8'hFF) ? count : count + 8'd1;
  end

  // Count register: cleared whenever no request is outstanding.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count_next;
    end
  end

  assign expired = enable && (count_next == TIMEOUT);

endmodule

// File: rtl/audioplay_proce_cpu_debug_mem_bridge.sv
// Debug memory-access engine: turns JTAG ocimem commands into single-word
// Avalon-MM reads/writes against the CPU debug RAM/ROM and reports the result
// through MonDReg, monitor_ready and a sticky monitor_error.
module audioplay_proce_cpu_debug_mem_bridge
  import audioplay_proce_cpu_debug_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [JDO_W-1:0]    jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  input  logic                take_no_action_ocimem_a,
  output logic [ADDR_W+1:0]   dbg_address,
  output logic                dbg_read,
  output logic                dbg_write,
  output logic [DATA_W-1:0]   dbg_writedata,
  output logic [3:0]          dbg_byteenable,
  input  logic [DATA_W-1:0]   dbg_readdata,
  input  logic                dbg_waitrequest,
  output logic [DATA_W-1:0]   MonDReg,
  output logic                monitor_ready,
  output logic                monitor_error
);

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   mon_addr;
  logic                busy;
  logic                any_strobe;
  logic                accept_a;
  logic                accept_b;
  logic                accept_na;
  logic                done;
  logic                abort;
  logic                expired;
  logic                err_set;
  logic                err_clr;
  logic                unused_jdo;

  assign busy       = (state != IDLE);
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // Commands are only honoured when idle; ocimem_a outranks ocimem_b, which outranks no_action_a.
  assign accept_a  = !busy && take_action_ocimem_a;
  assign accept_b  = !busy && !take_action_ocimem_a && take_action_ocimem_b;
  assign accept_na = !busy && !take_action_ocimem_a && !take_action_ocimem_b && take_no_action_ocimem_a;

  assign done  = busy && !dbg_waitrequest;
  assign abort = busy && dbg_waitrequest && expired;

  assign err_set = abort || (busy && any_strobe);
  assign err_clr = accept_a && jdo[JDO_CLR_BIT];

  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_DATA_LSB-1:0]};

  audioplay_proce_cpu_debug_req_timer #(
    .TIMEOUT (8'(TIMEOUT))
  ) u_req_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!busy),
    .enable  (busy && dbg_waitrequest),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: launch from IDLE, return on completion or timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_a && jdo[JDO_RD_BIT]) begin
          state_next = RD;
        end else if (accept_b) begin
          state_next = WR;
        end else if (accept_na) begin
          state_next = RD;
        end
      end
      RD, WR: begin
        if (done || abort) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus requests and ready flag follow the registered state directly.
  always_comb begin
    dbg_read      = 1'b0;
    dbg_write     = 1'b0;
    monitor_ready = 1'b0;
    case (state)
      RD:      dbg_read      = 1'b1;
      WR:      dbg_write     = 1'b1;
      default: monitor_ready = 1'b1;
    endcase
  end

  // Address, data and error registers updated on command accept and access end.
  always_ff @(posedge clk) begin
    if (reset) begin
      mon_addr      <= '0;
      MonDReg       <= '0;
      dbg_writedata <= '0;
      monitor_error <= 1'b0;
    end else begin
      if (accept_a) begin
        mon_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
      end else if (done || abort) begin
        mon_addr <= mon_addr + 1'b1;
      end

      if (accept_b) begin
        MonDReg       <= jdo[JDO_DATA_LSB +: DATA_W];
        dbg_writedata <= jdo[JDO_DATA_LSB +: DATA_W];
      end else if (done && (state == RD)) begin
        MonDReg <= dbg_readdata;
      end

      monitor_error <= (monitor_error && !err_clr) || err_set;
    end
  end

  assign dbg_address    = {mon_addr, 2'b00};
  assign dbg_byteenable = 4'hF;

endmodule

// File: tb/tb_audioplay_proce_cpu_debug_mem_bridge.sv
// Directed bench for the CPU debug memory bridge: a vector table for the
// single-cycle command/response behaviour plus hand-written sequences for
// timeout and mid-access reset.
module tb_audioplay_proce_cpu_debug_mem_bridge;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic        rdy;
    logic        err;
    logic [31:0] mond;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    logic        a;
    logic        b;
    logic        na;
    logic [37:0] jdo;
    logic        wait_req;
    logic [31:0] rdata;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [11:0] dbg_address;
  logic        dbg_read;
  logic        dbg_write;
  logic [31:0] dbg_writedata;
  logic [3:0]  dbg_byteenable;
  logic [31:0] dbg_readdata;
  logic        dbg_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int tests_run    = 0;
  int tests_failed = 0;

  vec_t vecs[18];

  audioplay_proce_cpu_debug_mem_bridge dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .dbg_address             (dbg_address),
    .dbg_read                (dbg_read),
    .dbg_write               (dbg_write),
    .dbg_writedata           (dbg_writedata),
    .dbg_byteenable          (dbg_byteenable),
    .dbg_readdata            (dbg_readdata),
    .dbg_waitrequest         (dbg_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [37:0] addrJdo(input logic rd, input logic clr, input logic [9:0] addr);
    logic [37:0] j;
    j = '0;
    j[34]   = rd;
    j[33]   = clr;
    j[17:8] = addr;
    return j;
  endfunction

  function automatic logic [37:0] dataJdo(input logic [31:0] data);
    logic [37:0] j;
    j = '0;
    j[34:3] = data;
    return j;
  endfunction

  function automatic exp_t mkExp(input logic rd, input logic wr, input logic [11:0] addr,
                                 input logic rdy, input logic err,
                                 input logic [31:0] mond, input logic [31:0] wdata);
    exp_t e;
    e.rd = rd; e.wr = wr; e.addr = addr; e.rdy = rdy;
    e.err = err; e.mond = mond; e.wdata = wdata;
    return e;
  endfunction

  function automatic vec_t mkVec(input logic a, input logic b, input logic na,
                                 input logic [37:0] j, input logic w, input logic [31:0] rdata,
                                 input exp_t e);
    vec_t v;
    v.a = a; v.b = b; v.na = na; v.jdo = j;
    v.wait_req = w; v.rdata = rdata; v.e = e;
    return v;
  endfunction

  task automatic checkField(input string tag, input string field,
                            input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h", tag, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    checkField(tag, "dbg_read",      32'(dbg_read),      32'(e.rd));
    checkField(tag, "dbg_write",     32'(dbg_write),     32'(e.wr));
    checkField(tag, "dbg_address",   32'(dbg_address),   32'(e.addr));
    checkField(tag, "monitor_ready", 32'(monitor_ready), 32'(e.rdy));
    checkField(tag, "monitor_error", 32'(monitor_error), 32'(e.err));
    checkField(tag, "MonDReg",       MonDReg,            e.mond);
    checkField(tag, "dbg_writedata", dbg_writedata,      e.wdata);
  endtask

  // Drive one cycle of inputs before the edge, then settle just after it.
  task automatic applyStimulus(input logic a, input logic b, input logic na,
                               input logic [37:0] j, input logic w, input logic [31:0] rdata);
    @(negedge clk);
    take_action_ocimem_a    = a;
    take_action_ocimem_b    = b;
    take_no_action_ocimem_a = na;
    jdo                     = j;
    dbg_waitrequest         = w;
    dbg_readdata            = rdata;
    @(posedge clk);
    #1;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  initial begin
    int high_cycles;

    // Write, stalled read, dropped ocimem_b, wrap, overrun and error clear.
    vecs[0]  = mkVec(1,0,0, addrJdo(0,0,10'h010), 0, 32'h0,
                     mkExp(0,0,12'h040,1,0,32'h0,32'h0));
    vecs[1]  = mkVec(0,1,0, dataJdo(32'hCAFEF00D), 0, 32'h0,
                     mkExp(0,1,12'h040,0,0,32'hCAFEF00D,32'hCAFEF00D));
    vecs[2]  = mkVec(0,0,0, '0, 0, 32'h0,
                     mkExp(0,0,12'h044,1,0,32'hCAFEF00D,32'hCAFEF00D));
    vecs[3]  = mkVec(1,0,0, addrJdo(1,0,10'h010), 1, 32'h0,
                     mkExp(1,0,12'h040,0,0,32'hCAFEF00D,32'hCAFEF00D));
    vecs[4]  = mkVec(0,0,0, '0, 1, 32'h0,
                     mkExp(1,0,12'h040,0,0,32'hCAFEF00D,32'hCAFEF00D));
    vecs[5]  = mkVec(0,0,0, '0, 1, 32'h0,
                     mkExp(1,0,12'h040,0,0,32'hCAFEF00D,32'hCAFEF00D));
    vecs[6]  = mkVec(0,0,0, '0, 1, 32'h0,
                     mkExp(1,0,12'h040,0,0,32'hCAFEF00D,32'hCAFEF00D));
    vecs[7]  = mkVec(0,0,0, '0, 0, 32'h12345678,
                     mkExp(0,0,12'h044,1,0,32'h12345678,32'hCAFEF00D));
    vecs[8]  = mkVec(1,1,0, addrJdo(0,0,10'h3FF), 0, 32'h0,
                     mkExp(0,0,12'hFFC,1,0,32'h12345678,32'hCAFEF00D));
    vecs[9]  = mkVec(0,0,1, '0, 1, 32'h0,
                     mkExp(1,0,12'hFFC,0,0,32'h12345678,32'hCAFEF00D));
    vecs[10] = mkVec(0,0,1, '0, 1, 32'h0,
                     mkExp(1,0,12'hFFC,0,1,32'h12345678,32'hCAFEF00D));
    vecs[11] = mkVec(0,0,0, '0, 0, 32'hA5A55A5A,
                     mkExp(0,0,12'h000,1,1,32'hA5A55A5A,32'hCAFEF00D));
    vecs[12] = mkVec(0,0,0, '0, 0, 32'h0,
                     mkExp(0,0,12'h000,1,1,32'hA5A55A5A,32'hCAFEF00D));
    vecs[13] = mkVec(1,0,0, addrJdo(0,1,10'h005), 0, 32'h0,
                     mkExp(0,0,12'h014,1,0,32'hA5A55A5A,32'hCAFEF00D));
    vecs[14] = mkVec(0,1,0, dataJdo(32'h0BADBEEF), 1, 32'h0,
                     mkExp(0,1,12'h014,0,0,32'h0BADBEEF,32'h0BADBEEF));
    vecs[15] = mkVec(0,0,0, '0, 0, 32'h0,
                     mkExp(0,0,12'h018,1,0,32'h0BADBEEF,32'h0BADBEEF));
    vecs[16] = mkVec(0,0,1, '0, 1, 32'h0,
                     mkExp(1,0,12'h018,0,0,32'h0BADBEEF,32'h0BADBEEF));
    vecs[17] = mkVec(1,0,0, addrJdo(0,1,10'h100), 0, 32'h00000042,
                     mkExp(0,0,12'h01C,1,1,32'h00000042,32'h0BADBEEF));

    reset                   = 1'b1;
    jdo                     = '0;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    dbg_readdata            = '0;
    dbg_waitrequest         = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", mkExp(0,0,12'h000,1,0,32'h0,32'h0));
    checkField("reset", "dbg_byteenable", 32'(dbg_byteenable), 32'hF);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].na, vecs[i].jdo, vecs[i].wait_req, vecs[i].rdata);
      checkOutput($sformatf("vec%0d", i), vecs[i].e);
    end

    // Clear the error left by the overrun before the timeout sequence.
    applyStimulus(1,0,0, addrJdo(0,1,10'h020), 0, 32'h0);
    checkOutput("preclear", mkExp(0,0,12'h080,1,0,32'h00000042,32'h0BADBEEF));

    // Timeout: waitrequest stuck high, read must stay up exactly 255 cycles.
    applyStimulus(0,0,1, '0, 1, 32'hDEADDEAD);
    high_cycles = dbg_read ? 1 : 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (!dbg_read) break;
      high_cycles++;
    end
    checkField("timeout", "read_cycles", 32'(high_cycles), 32'd255);
    checkOutput("timeout", mkExp(0,0,12'h084,1,1,32'h00000042,32'h0BADBEEF));
    applyStimulus(0,0,0, '0, 0, 32'h0);
    checkOutput("timeout_after", mkExp(0,0,12'h084,1,1,32'h00000042,32'h0BADBEEF));
    applyStimulus(1,0,0, addrJdo(0,1,10'h030), 0, 32'h0);
    checkOutput("timeout_clear", mkExp(0,0,12'h0C0,1,0,32'h00000042,32'h0BADBEEF));

    // Reset in the middle of a stalled read, with the error flag set by an overrun.
    applyStimulus(0,0,1, '0, 1, 32'h0);
    checkOutput("mid_launch", mkExp(1,0,12'h0C0,0,0,32'h00000042,32'h0BADBEEF));
    applyStimulus(0,0,1, '0, 1, 32'h0);
    checkOutput("mid_overrun", mkExp(1,0,12'h0C0,0,1,32'h00000042,32'h0BADBEEF));
    @(negedge clk);
    reset = 1'b1;
    dbg_readdata = 32'h77777777;
    @(posedge clk);
    #1;
    checkOutput("mid_reset", mkExp(0,0,12'h000,1,0,32'h0,32'h0));
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0,0,0, '0, 0, 32'h77777777);
    checkOutput("post_reset", mkExp(0,0,12'h000,1,0,32'h0,32'h0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
